// File: rtl/cnet_reg_access_mt.sv
// Multi-slot CNET register access path: turns PCI delayed reads into CNET reads with up to
// NUM_SLOTS results in flight, and passes writes straight through to the request FIFO.
module cnet_reg_access_mt #(
  parameter int PCI_ADDR_WIDTH  = 32,
  parameter int PCI_DATA_WIDTH  = 32,
  parameter int CNET_ADDR_WIDTH = 27,
  parameter int CNET_DATA_WIDTH = 32,
  parameter int NUM_SLOTS       = 4,
  parameter int DISCARD_CYCLES  = 65535
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [PCI_ADDR_WIDTH-1:0]        pci_addr,
  input  logic [PCI_DATA_WIDTH-1:0]        pci_data,
  input  logic                             pci_data_vld,
  input  logic                             cnet_we,
  input  logic                             cnet_hit,
  output logic [PCI_DATA_WIDTH-1:0]        cnet_data,
  output logic                             cnet_vld,
  output logic                             cnet_retry,
  output logic [CNET_DATA_WIDTH-1:0]       p2n_data,
  output logic [CNET_ADDR_WIDTH-1:0]       p2n_addr,
  output logic                             p2n_we,
  output logic                             p2n_req,
  input  logic                             p2n_full,
  input  logic [CNET_DATA_WIDTH-1:0]       n2p_data,
  input  logic                             n2p_rd_rdy,
  input  logic                             cnet_reprog,
  output logic [$clog2(NUM_SLOTS+1)-1:0]   slots_busy,
  output logic [15:0]                      discard_cnt,
  output logic                             resp_err
);
  localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = $clog2(NUM_SLOTS+1);
  localparam logic [15:0] TIMER_LOAD = 16'(DISCARD_CYCLES - 1);

  // state     | meaning
  // FREE      | slot unused
  // WAIT_CNET | read issued, response pending (index queued in issue order)
  // WAIT_PCI  | data held for the PCI master; discard timer running unless being served
  typedef enum logic [1:0] {FREE, WAIT_CNET, WAIT_PCI} slot_state_t;

  slot_state_t                st      [NUM_SLOTS];
  logic [CNET_ADDR_WIDTH-1:0] s_addr  [NUM_SLOTS];
  logic [CNET_DATA_WIDTH-1:0] s_data  [NUM_SLOTS];
  logic [15:0]                s_timer [NUM_SLOTS];
  logic [IW-1:0]              q       [NUM_SLOTS];
  logic [IW-1:0]              q_rd, q_wr, served_idx, pci_idx, free_idx, data_idx;
  logic [CW-1:0]              q_cnt, busy, n_exp;
  logic [NUM_SLOTS-1:0]       expire;
  logic                       hit_d1, served_vld, trans_start, trans_done;
  logic                       pci_hit, cnet_match, free_any;
  logic                       serve_now, alloc, wr_issue, resp_take, reading_ok;
  logic [CNET_ADDR_WIDTH-1:0] addr_c;
  logic [16:0]                discard_nxt;
  logic                       unused_addr_bits;

  assign unused_addr_bits = &{1'b0, pci_addr[PCI_ADDR_WIDTH-1:CNET_ADDR_WIDTH]};
  assign addr_c      = pci_addr[CNET_ADDR_WIDTH-1:0];
  assign trans_start = cnet_hit & ~hit_d1;
  assign trans_done  = hit_d1 & ~cnet_hit;

  always_comb begin
    pci_hit    = 1'b0;
    pci_idx    = '0;
    cnet_match = 1'b0;
    free_any   = 1'b0;
    free_idx   = '0;
    busy       = '0;
    for (int i = NUM_SLOTS-1; i >= 0; i--) begin
      if (st[i] == FREE) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end else begin
        busy = busy + CW'(1);
        if (s_addr[i] == addr_c) begin
          if (st[i] == WAIT_PCI) begin
            pci_hit = 1'b1;
            pci_idx = IW'(i);
          end else begin
            cnet_match = 1'b1;
          end
        end
      end
    end
  end

  assign serve_now  = trans_start & ~cnet_we & pci_hit & ~cnet_reprog;
  assign alloc      = trans_start & ~cnet_we & ~pci_hit & ~cnet_match & free_any & ~p2n_full & ~cnet_reprog;
  assign wr_issue   = cnet_hit & cnet_we & pci_data_vld & ~p2n_full & ~cnet_match & ~cnet_reprog;
  assign resp_take  = n2p_rd_rdy & ~cnet_reprog & (q_cnt != '0);
  assign reading_ok = served_vld | serve_now;

  assign cnet_vld   = cnet_hit & ~cnet_we & ~cnet_reprog & reading_ok;
  assign cnet_retry = cnet_hit & ~cnet_reprog & (cnet_we ? (p2n_full | cnet_match) : ~reading_ok);
  assign data_idx   = served_vld ? served_idx : pci_idx;
  assign cnet_data  = cnet_vld ? PCI_DATA_WIDTH'(s_data[data_idx]) : '0;
  assign slots_busy = busy;

  // A slot being served (now or earlier in this transaction) never expires.
  always_comb begin
    expire = '0;
    n_exp  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (st[i] == WAIT_PCI && s_timer[i] == 16'd0 && !cnet_reprog &&
          !(served_vld && served_idx == IW'(i)) && !(serve_now && pci_idx == IW'(i))) begin
        expire[i] = 1'b1;
        n_exp     = n_exp + CW'(1);
      end
    end
  end

  assign discard_nxt = {1'b0, discard_cnt} + 17'(n_exp);

  function automatic logic [IW-1:0] q_next(input logic [IW-1:0] p);
    return (p == IW'(NUM_SLOTS-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        st[i]      <= FREE;
        s_addr[i]  <= '0;
        s_data[i]  <= '0;
        s_timer[i] <= '0;
        q[i]       <= '0;
      end
      q_rd        <= '0;
      q_wr        <= '0;
      q_cnt       <= '0;
      hit_d1      <= 1'b0;
      served_vld  <= 1'b0;
      served_idx  <= '0;
      p2n_req     <= 1'b0;
      p2n_we      <= 1'b0;
      p2n_addr    <= '0;
      p2n_data    <= '0;
      discard_cnt <= '0;
      resp_err    <= 1'b0;
    end else begin
      hit_d1  <= cnet_hit;
      p2n_req <= 1'b0;
      if (n2p_rd_rdy && !cnet_reprog && q_cnt == '0) resp_err <= 1'b1;
      discard_cnt <= discard_nxt[16] ? 16'hFFFF : discard_nxt[15:0];
      if (cnet_reprog) begin
        for (int i = 0; i < NUM_SLOTS; i++) st[i] <= FREE;
        q_rd       <= '0;
        q_wr       <= '0;
        q_cnt      <= '0;
        served_vld <= 1'b0;
        p2n_we     <= 1'b0;
        p2n_addr   <= '0;
        p2n_data   <= '0;
      end else begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (expire[i]) st[i] <= FREE;
          else if (st[i] == WAIT_PCI && s_timer[i] != 16'd0 &&
                   !(served_vld && served_idx == IW'(i)) && !(serve_now && pci_idx == IW'(i)))
            s_timer[i] <= s_timer[i] - 16'd1;
        end
        if (trans_done && served_vld) begin
          st[served_idx] <= FREE;
          served_vld     <= 1'b0;
        end
        if (serve_now) begin
          served_vld <= 1'b1;
          served_idx <= pci_idx;
        end
        if (alloc) begin
          st[free_idx]     <= WAIT_CNET;
          s_addr[free_idx] <= addr_c;
          q[q_wr]          <= free_idx;
          q_wr             <= q_next(q_wr);
          p2n_req          <= 1'b1;
          p2n_we           <= 1'b0;
          p2n_addr         <= addr_c;
          p2n_data         <= '0;
        end
        if (wr_issue) begin
          p2n_req  <= 1'b1;
          p2n_we   <= 1'b1;
          p2n_addr <= addr_c;
          p2n_data <= pci_data[CNET_DATA_WIDTH-1:0];
        end
        if (resp_take) begin
          st[q[q_rd]]      <= WAIT_PCI;
          s_data[q[q_rd]]  <= n2p_data;
          s_timer[q[q_rd]] <= TIMER_LOAD;
          q_rd             <= q_next(q_rd);
        end
        q_cnt <= q_cnt + CW'(alloc) - CW'(resp_take);
      end
    end
  end
endmodule

// File: tb/tb_cnet_reg_access_mt.sv
// Directed bench for cnet_reg_access_mt: reads, multi-slot ordering, writes, discard, reprogram.
module tb_cnet_reg_access_mt;
  localparam int DISC = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pci_addr = '0, pci_data = '0;
  logic        pci_data_vld = 1'b0, cnet_we = 1'b0, cnet_hit = 1'b0;
  logic [31:0] cnet_data;
  logic        cnet_vld, cnet_retry;
  logic [31:0] p2n_data;
  logic [26:0] p2n_addr;
  logic        p2n_we, p2n_req;
  logic        p2n_full = 1'b0;
  logic [31:0] n2p_data = '0;
  logic        n2p_rd_rdy = 1'b0, cnet_reprog = 1'b0;
  logic [2:0]  slots_busy;
  logic [15:0] discard_cnt;
  logic        resp_err;

  int n_cmp = 0, n_bad = 0;
  logic        seen_req, seen_we;
  logic [26:0] seen_addr;

  always #5 clk = ~clk;

  cnet_reg_access_mt #(.DISCARD_CYCLES(DISC)) dut (
    .clk(clk), .reset(reset), .pci_addr(pci_addr), .pci_data(pci_data),
    .pci_data_vld(pci_data_vld), .cnet_we(cnet_we), .cnet_hit(cnet_hit),
    .cnet_data(cnet_data), .cnet_vld(cnet_vld), .cnet_retry(cnet_retry),
    .p2n_data(p2n_data), .p2n_addr(p2n_addr), .p2n_we(p2n_we), .p2n_req(p2n_req),
    .p2n_full(p2n_full), .n2p_data(n2p_data), .n2p_rd_rdy(n2p_rd_rdy),
    .cnet_reprog(cnet_reprog), .slots_busy(slots_busy), .discard_cnt(discard_cnt),
    .resp_err(resp_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Start a read, check the start-cycle outputs, capture what reached the request port.
  task automatic pci_read(input logic [31:0] a, input logic exp_vld, input logic [31:0] exp_data,
                          input string tag);
    cnet_hit = 1'b1; cnet_we = 1'b0; pci_addr = a;
    #1;
    check({tag, ".vld"},   64'(cnet_vld),   64'(exp_vld));
    check({tag, ".retry"}, 64'(cnet_retry), 64'(!exp_vld));
    check({tag, ".data"},  64'(cnet_data),  exp_vld ? 64'(exp_data) : 64'd0);
    cyc();
    seen_req = p2n_req; seen_addr = p2n_addr; seen_we = p2n_we;
    check({tag, ".vld2"}, 64'(cnet_vld), 64'(exp_vld));
    cnet_hit = 1'b0;
    cyc();
  endtask

  task automatic respond(input logic [31:0] d);
    n2p_rd_rdy = 1'b1; n2p_data = d;
    cyc();
    n2p_rd_rdy = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check("rst.req",     64'(p2n_req),     64'd0);
    check("rst.busy",    64'(slots_busy),  64'd0);
    check("rst.discard", 64'(discard_cnt), 64'd0);
    check("rst.err",     64'(resp_err),    64'd0);
    check("rst.retry",   64'(cnet_retry),  64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cyc();

    // Single read round trip
    pci_read(32'h100, 1'b0, 32'h0, "r100a");
    check("r100a.req",  64'(seen_req),  64'd1);
    check("r100a.addr", 64'(seen_addr), 64'h100);
    check("r100a.we",   64'(seen_we),   64'd0);
    check("r100a.busy", 64'(slots_busy), 64'd1);
    check("r100a.pulse", 64'(p2n_req),  64'd0);
    respond(32'hDEADBEEF);
    pci_read(32'h100, 1'b1, 32'hDEADBEEF, "r100b");
    check("r100b.busy", 64'(slots_busy), 64'd0);
    check("r100b.err",  64'(resp_err),   64'd0);

    // Fill all slots, fifth read must not issue, collect out of order
    for (int i = 0; i < 4; i++) begin
      pci_read(32'h10 + 32'(i), 1'b0, 32'h0, "fill");
      check("fill.req",  64'(seen_req),  64'd1);
      check("fill.addr", 64'(seen_addr), 64'h10 + 64'(i));
    end
    check("fill.busy", 64'(slots_busy), 64'd4);
    pci_read(32'h14, 1'b0, 32'h0, "fifth");
    check("fifth.req", 64'(seen_req), 64'd0);
    for (int i = 0; i < 4; i++) respond(32'hA000_0000 + 32'(i));
    pci_read(32'h12, 1'b1, 32'hA000_0002, "col12");
    pci_read(32'h10, 1'b1, 32'hA000_0000, "col10");
    check("col.busy", 64'(slots_busy), 64'd2);
    pci_read(32'h11, 1'b1, 32'hA000_0001, "col11");
    pci_read(32'h13, 1'b1, 32'hA000_0003, "col13");
    check("col.busy0", 64'(slots_busy), 64'd0);

    // Write blocked by full FIFO, then passes
    p2n_full = 1'b1; cnet_hit = 1'b1; cnet_we = 1'b1; pci_addr = 32'h20;
    pci_data = 32'h0000_55AA; pci_data_vld = 1'b1;
    #1 check("wfull.retry", 64'(cnet_retry), 64'd1);
    cyc();
    check("wfull.req", 64'(p2n_req), 64'd0);
    cnet_hit = 1'b0; p2n_full = 1'b0;
    cyc();
    cnet_hit = 1'b1;
    #1 check("wok.retry", 64'(cnet_retry), 64'd0);
    cyc();
    check("wok.req",  64'(p2n_req),  64'd1);
    check("wok.we",   64'(p2n_we),   64'd1);
    check("wok.addr", 64'(p2n_addr), 64'h20);
    check("wok.data", 64'(p2n_data), 64'h55AA);
    cnet_hit = 1'b0; pci_data_vld = 1'b0; cnet_we = 1'b0;
    cyc();
    check("wok.pulse", 64'(p2n_req), 64'd0);

    // Write collides with pending read to the same address
    pci_read(32'h30, 1'b0, 32'h0, "r30");
    check("r30.req", 64'(seen_req), 64'd1);
    cnet_hit = 1'b1; cnet_we = 1'b1; pci_addr = 32'h30; pci_data_vld = 1'b1;
    #1 check("wcol.retry", 64'(cnet_retry), 64'd1);
    cyc();
    check("wcol.req", 64'(p2n_req), 64'd0);
    cnet_hit = 1'b0; cnet_we = 1'b0; pci_data_vld = 1'b0;
    cyc();

    // Unclaimed result is discarded after DISC cycles
    respond(32'h3030_3030);
    repeat (DISC - 1) cyc();
    check("disc.busy_hold", 64'(slots_busy),  64'd1);
    check("disc.cnt_hold",  64'(discard_cnt), 64'd0);
    cyc();
    check("disc.busy", 64'(slots_busy),  64'd0);
    check("disc.cnt",  64'(discard_cnt), 64'd1);
    pci_read(32'h30, 1'b0, 32'h0, "r30again");
    check("r30again.req",  64'(seen_req),  64'd1);
    check("r30again.addr", 64'(seen_addr), 64'h30);

    // Reprogram with three slots busy
    pci_read(32'h40, 1'b0, 32'h0, "r40");
    pci_read(32'h41, 1'b0, 32'h0, "r41");
    check("pre_rp.busy", 64'(slots_busy), 64'd3);
    cnet_reprog = 1'b1;
    cyc();
    check("rp.busy", 64'(slots_busy), 64'd0);
    check("rp.addr", 64'(p2n_addr),   64'd0);
    cnet_hit = 1'b1; pci_addr = 32'h40; n2p_rd_rdy = 1'b1;
    #1;
    check("rp.retry", 64'(cnet_retry), 64'd0);
    check("rp.vld",   64'(cnet_vld),   64'd0);
    cyc();
    check("rp.req", 64'(p2n_req),  64'd0);
    check("rp.err", 64'(resp_err), 64'd0);
    cnet_hit = 1'b0; n2p_rd_rdy = 1'b0; cnet_reprog = 1'b0;
    repeat (2) cyc();
    respond(32'h0);
    check("stray.err", 64'(resp_err), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
